// File: rtl/counter_cmd_ctrl.sv
// Command sequencer owning an up/down count register: LOAD, step UP/DOWN by N,
// or SEEK to a target one unit per clock, with done/aborted/wrap pulses.
module counter_cmd_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SIZE-1:0] cmd_arg,
  input  logic            abort,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            wrap
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] steps_left;
  logic [SIZE-1:0] target;
  logic            dir_up;
  logic            is_seek;

  logic            accept;
  logic            start_run;
  logic            step;
  logic            done_nxt;
  logic            aborted_nxt;
  logic            wrap_nxt;
  logic [SIZE-1:0] count_step;

  function automatic logic [SIZE-1:0] step_val(input logic [SIZE-1:0] v, input logic up);
    return up ? v + SIZE'(1) : v - SIZE'(1);
  endfunction

  // A step wraps when it leaves the all-ones value upward or zero downward.
  function automatic logic step_wraps(input logic [SIZE-1:0] v, input logic up);
    return up ? (v == {SIZE{1'b1}}) : (v == '0);
  endfunction

  assign accept     = cmd_valid && cmd_ready;
  assign count_step = step_val(count, dir_up);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    step        = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: done_nxt = 1'b1;
            OP_SEEK: begin
              if (cmd_arg == count) done_nxt = 1'b1;
              else begin
                start_run = 1'b1;
                state_nxt = RUN;
              end
            end
            default: begin
              if (cmd_arg == '0) done_nxt = 1'b1;
              else begin
                start_run = 1'b1;
                state_nxt = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        // Abort wins over stepping, including on the would-be final step.
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          step = 1'b1;
          if (is_seek ? (count_step == target) : (steps_left == SIZE'(1))) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
  end

  assign wrap_nxt = step && step_wraps(count, dir_up);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      steps_left <= '0;
      target     <= '0;
      dir_up     <= 1'b0;
      is_seek    <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      done    <= done_nxt;
      aborted <= aborted_nxt;
      wrap    <= wrap_nxt;
      if (accept && cmd_op == OP_LOAD) count <= cmd_arg;
      if (start_run) begin
        is_seek    <= (cmd_op == OP_SEEK);
        dir_up     <= (cmd_op == OP_UP) || (cmd_op == OP_SEEK && cmd_arg > count);
        steps_left <= cmd_arg;
        target     <= cmd_arg;
      end
      if (step) begin
        count      <= count_step;
        steps_left <= steps_left - SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Scoreboard bench for counter_cmd_ctrl: expected done/aborted/wrap events are
// queued by the stimulus and checked by a monitor whenever a pulse appears.
module tb_counter_cmd_ctrl;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'b00;
  logic [SIZE-1:0] cmd_arg = '0;
  logic            abort = 1'b0;
  logic [SIZE-1:0] count;
  logic            busy, done, aborted, wrap;

  int checks = 0;
  int errors = 0;

  // Expected event: {done, aborted, wrap, count}
  logic [6:0] exp_q[$];

  counter_cmd_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .count(count),
    .busy(busy), .done(done), .aborted(aborted), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (done || aborted || wrap)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got d/a/w/count=%b%b%b/%0d, none expected", done, aborted, wrap, count);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        if ({done, aborted, wrap, count} !== e)
          begin
            errors++;
            $display("FAIL event: got d/a/w/count=%b%b%b/%0d, expected %b%b%b/%0d",
                     done, aborted, wrap, count, e[6], e[5], e[4], e[3:0]);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic d, input logic a, input logic w, input logic [SIZE-1:0] c);
    exp_q.push_back({d, a, w, c});
  endtask

  task automatic issue(input logic [1:0] op, input logic [SIZE-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts cycles spent busy after an accept, bounded by max_cyc.
  task automatic run_len(input string name, input int req, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk(name, n, req);
  endtask

  initial begin
    #12;
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", {done, aborted, wrap}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", cmd_ready, 1);

    // LOAD 9
    expect_ev(1, 0, 0, 4'd9);
    issue(2'b00, 4'd9);
    chk("load_count", count, 9);
    chk("load_ready", cmd_ready, 1);
    chk("load_busy", busy, 0);

    // LOAD 14, UP 3 with wrap on 15->0
    expect_ev(1, 0, 0, 4'd14);
    issue(2'b00, 4'd14);
    expect_ev(0, 0, 1, 4'd0);
    expect_ev(1, 0, 0, 4'd1);
    issue(2'b01, 4'd3);
    run_len("up3_cycles", 3, 20);
    chk("up3_count", count, 1);

    // LOAD 2, DOWN 0
    expect_ev(1, 0, 0, 4'd2);
    issue(2'b00, 4'd2);
    expect_ev(1, 0, 0, 4'd2);
    issue(2'b10, 4'd0);
    chk("down0_busy", busy, 0);
    chk("down0_count", count, 2);

    // SEEK up, SEEK down, SEEK to current value
    expect_ev(1, 0, 0, 4'd3);
    issue(2'b00, 4'd3);
    expect_ev(1, 0, 0, 4'd12);
    issue(2'b11, 4'd12);
    run_len("seek12_cycles", 9, 30);
    chk("seek12_count", count, 12);
    expect_ev(1, 0, 0, 4'd5);
    issue(2'b11, 4'd5);
    run_len("seek5_cycles", 7, 30);
    chk("seek5_count", count, 5);
    expect_ev(1, 0, 0, 4'd5);
    issue(2'b11, 4'd5);
    chk("seek_same_busy", busy, 0);

    // LOAD 0, UP 10, abort in 4th RUN cycle
    expect_ev(1, 0, 0, 4'd0);
    issue(2'b00, 4'd0);
    issue(2'b01, 4'd10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_pre_count", count, 3);
    expect_ev(0, 1, 0, 4'd3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_count", count, 3);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("abort_hold_count", count, 3);

    // UP 8; LOAD 7 during RUN is ignored; async reset mid-RUN
    issue(2'b01, 4'd8);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_arg   = 4'd7;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("ignored_load_count", count, 5);
    chk("ignored_load_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", count, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ready", cmd_ready, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_count", count, 0);

    expect_ev(1, 0, 0, 4'd6);
    issue(2'b00, 4'd6);
    @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
